// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and access sequencer for
// the scratch memory. Each transaction runs IDLE -> ACCESS -> DONE, which
// gives one transaction per three cycles. Address, write data and write
// enable come from registers, so the memory sees stable inputs for a whole
// cycle.
//
// Optional build macro: MEM_ARB_CLEAR_EN
//   When it is defined, leaving reset enters a CLEAR sweep. The sweep
//   writes zero to cells 0..CELL_COUNT-1, one cell per cycle, and then
//   moves to IDLE.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req/we/addr/wdata{0,1}  requester transaction inputs, held until ack
//   gnt{0,1}                requester owns the memory (ACCESS cycle)
//   ack{0,1}                one-cycle completion pulse (DONE cycle)
//   rdata{0,1}              registered read result, held until the next read
//   mem_*                   memory port (read addr, write addr/data/enable, read data)
//   busy                    arbiter is not in IDLE
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter int CELL_COUNT = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  // The clear sweep addresses every cell, so the cells must fit the address space.
  if (CELL_COUNT > (1 << ADDR_WIDTH)) begin : g_bad_cell_count
    $error("mem_arbiter: CELL_COUNT exceeds address space");
  end

`ifdef MEM_ARB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                state, state_d;
  logic                  last_grant, sel;
  logic                  take, pick;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

`ifdef MEM_ARB_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clearing;
`endif

  // Next state. A request is sampled only in IDLE. On a tie the requester
  // that did not win last time is chosen.
  always_comb begin
    state_d = state;
    take    = 1'b0;
    pick    = 1'b0;
    case (state)
      IDLE: if (req0 || req1) begin
        take    = 1'b1;
        pick    = (req0 && req1) ? ~last_grant : req1;
        state_d = ACCESS;
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
`ifdef MEM_ARB_CLEAR_EN
      CLEAR:   if (clr_cnt == ADDR_WIDTH'(CELL_COUNT - 1)) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RESET_STATE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_d;
      if (take) begin
        last_grant <= pick;
        sel        <= pick;
        we_q       <= pick ? we1    : we0;
        addr_q     <= pick ? addr1  : addr0;
        wdata_q    <= pick ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        // The write enable lasts only for the ACCESS cycle. Address and data
        // keep their values through DONE and IDLE.
        we_q <= 1'b0;
        if (!we_q) begin
          if (sel) rdata1 <= mem_read_data;
          else     rdata0 <= mem_read_data;
        end
      end
    end
  end

  assign gnt0             = (state == ACCESS) && !sel;
  assign gnt1             = (state == ACCESS) &&  sel;
  assign ack0             = (state == DONE)   && !sel;
  assign ack1             = (state == DONE)   &&  sel;
  assign mem_read_address = addr_q;

`ifdef MEM_ARB_CLEAR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              clr_cnt <= '0;
    else if (state == CLEAR)   clr_cnt <= clr_cnt + 1'b1;
  end

  // CLEAR is the reset state. It is qualified with reset_n so that the
  // outputs stay quiet while reset is held.
  assign clearing          = (state == CLEAR) && reset_n;
  assign mem_write_enable  = we_q | clearing;
  assign mem_write_address = clearing ? clr_cnt : addr_q;
  assign mem_write_data    = clearing ? '0 : wdata_q;
  assign busy              = reset_n && (state != IDLE);
`else
  assign mem_write_enable  = we_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
  assign busy              = (state != IDLE);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It has a behavioural memory and a
// transaction-level reference model. Each granted transaction lives for two
// cycles after its grant edge: first it owns the memory, then it is
// acknowledged.
module tb_mem_arbiter;
  logic       clk = 1'b0, reset_n = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0;
  logic [3:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, ack0, gnt1, ack1, mem_write_enable, busy;
  logic [3:0] rdata0, rdata1, mem_write_data, mem_read_data;
  logic [7:0] mem_read_address, mem_write_address;

  logic [3:0] mem [256];
  logic [3:0] ref_mem [256];

  int n_checks = 0, n_err = 0, cyc = 0;

  // reference model state
  int         age = 0;          // 0 none, 1 owns memory, 2 acknowledging
  bit         m_who = 1'b0, m_last = 1'b1, m_we = 1'b0;
  logic [7:0] m_addr = '0;
  logic [3:0] m_wdata = '0;
  logic [3:0] m_rdata [2];
  logic [33:0] obs, exp_v;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_read_address];
  assign obs = {busy, gnt0, gnt1, ack0, ack1, mem_write_enable, mem_read_address,
                mem_write_address, mem_write_data, rdata0, rdata1};

  function automatic logic [33:0] model_view();
    return {age != 0, age == 1 && !m_who, age == 1 && m_who, age == 2 && !m_who,
            age == 2 && m_who, age == 1 && m_we, m_addr, m_addr, m_wdata,
            m_rdata[0], m_rdata[1]};
  endfunction

  task automatic model_reset();
    age = 0; m_who = 1'b0; m_last = 1'b1; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    exp_v = model_view();
  endtask

  // Advance from one negedge to the next. Apply memory writes, then step the model.
  task automatic tick();
    logic pw, r0, r1, w0, w1;
    logic [7:0] pa, a0, a1;
    logic [3:0] pd, d0, d1;
    pw = mem_write_enable; pa = mem_write_address; pd = mem_write_data;
    r0 = req0; r1 = req1; w0 = we0; w1 = we1;
    a0 = addr0; a1 = addr1; d0 = wdata0; d1 = wdata1;
    @(posedge clk);
    if (pw) mem[pa] = pd;
    if (age == 2) age = 0;
    else if (age == 1) begin
      age = 2;
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_rdata[m_who] = ref_mem[m_addr];
    end else if (r0 || r1) begin
      m_who   = (r0 && r1) ? !m_last : r1;
      m_last  = m_who;
      m_we    = m_who ? w1 : w0;
      m_addr  = m_who ? a1 : a0;
      m_wdata = m_who ? d1 : d0;
      age     = 1;
    end
    @(negedge clk);
    cyc++;
    exp_v = model_view();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic poke(input logic [7:0] a, input logic [3:0] d);
    mem[a] = d; ref_mem[a] = d;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (obs !== 34'h0) begin n_err++; $display("FAIL reset_hold: got %h want 0", obs); end
    reset_n = 1'b1;
    model_reset();
    tick();
    n_checks++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_write_read();
    int we_cnt = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 4'hA;
    tick(); we_cnt += int'(mem_write_enable);
    n_checks++;
    if (obs !== exp_v) begin n_err++; $display("FAIL wr_access: got %h want %h", obs, exp_v); end
    n_checks++;
    if ({gnt0, gnt1, mem_write_enable} !== 3'b101) begin
      n_err++; $display("FAIL wr_gnt_we: got %b want 101", {gnt0, gnt1, mem_write_enable});
    end
    tick(); we_cnt += int'(mem_write_enable);
    n_checks++;
    if ({ack0, ack1, gnt0, mem_write_enable} !== 4'b1000) begin
      n_err++; $display("FAIL wr_ack: got %b want 1000", {ack0, ack1, gnt0, mem_write_enable});
    end
    req0 = 1'b0;
    tick(); we_cnt += int'(mem_write_enable);
    req0 = 1'b1; we0 = 1'b0;
    tick(); we_cnt += int'(mem_write_enable);
    tick(); we_cnt += int'(mem_write_enable);
    n_checks++;
    if ({ack0, rdata0} !== {1'b1, 4'hA}) begin
      n_err++; $display("FAIL rd_ack_data: got %b/%h want 1/a", ack0, rdata0);
    end
    n_checks++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rd_done: got %h want %h", obs, exp_v); end
    req0 = 1'b0;
    tick();
    n_checks++;
    if (we_cnt !== 1) begin n_err++; $display("FAIL we_cycles: got %0d want 1", we_cnt); end
  endtask

  task automatic test_tie();
    logic [3:0] ord = '0;
    int n_g = 0, last_ack = -1;
    do_reset();
    poke(8'h01, 4'h5); poke(8'h02, 4'h9);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_v) begin n_err++; $display("FAIL tie_cycle: got %h want %h", obs, exp_v); end
      n_checks++;
      if (gnt0 && gnt1) begin n_err++; $display("FAIL tie_both_gnt: got 11 want not both"); end
      if (gnt0 || gnt1) begin ord = {ord[2:0], gnt1}; n_g++; end
      if (ack0 || ack1) begin
        if (last_ack >= 0) begin
          n_checks++;
          if (cyc - last_ack !== 3) begin
            n_err++; $display("FAIL tie_ack_gap: got %0d want 3", cyc - last_ack);
          end
        end
        last_ack = cyc;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_checks++;
    if ({n_g, ord} !== {32'd4, 4'b0101}) begin
      n_err++; $display("FAIL tie_order: got %0d grants %b want 4 grants 0101", n_g, ord);
    end
    n_checks++;
    if ({rdata0, rdata1} !== 8'h59) begin
      n_err++; $display("FAIL tie_rdata: got %h want 59", {rdata0, rdata1});
    end
  endtask

  task automatic test_sole();
    logic [3:0] r0_before, v;
    int n1 = 0, n0 = 0, last_g = -1;
    r0_before = rdata0;
    v = 4'($urandom_range(15));
    poke(8'h30, v);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h30;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_v) begin n_err++; $display("FAIL sole_cycle: got %h want %h", obs, exp_v); end
      n0 += int'(gnt0);
      if (gnt1) begin
        n1++;
        if (last_g >= 0) begin
          n_checks++;
          if (cyc - last_g !== 3) begin n_err++; $display("FAIL sole_gap: got %0d want 3", cyc - last_g); end
        end
        last_g = cyc;
      end
    end
    req1 = 1'b0;
    n_checks++;
    if ({n1, n0} !== {32'd4, 32'd0}) begin
      n_err++; $display("FAIL sole_counts: got gnt1=%0d gnt0=%0d want 4/0", n1, n0);
    end
    n_checks++;
    if ({rdata0, rdata1} !== {r0_before, v}) begin
      n_err++; $display("FAIL sole_rdata: got %h want %h", {rdata0, rdata1}, {r0_before, v});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    poke(8'h20, 4'h1);
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 4'h6;
    tick();
    n_checks++;
    if ({gnt1, mem_write_enable} !== 2'b11) begin
      n_err++; $display("FAIL mid_access: got %b want 11", {gnt1, mem_write_enable});
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 34'h0) begin n_err++; $display("FAIL mid_reset_outputs: got %h want 0", obs); end
    req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (mem[8'h20] !== 4'h1) begin n_err++; $display("FAIL mid_no_write: got %h want 1", mem[8'h20]); end
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_v) begin n_err++; $display("FAIL mid_after: got %h want %h", obs, exp_v); end
    end
  endtask

  task automatic test_rdata_hold();
    poke(8'h05, 4'h3);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
    tick(); tick();
    n_checks++;
    if ({ack1, rdata1} !== {1'b1, 4'h3}) begin
      n_err++; $display("FAIL hold_first_read: got %b/%h want 1/3", ack1, rdata1);
    end
    we1 = 1'b1; wdata1 = 4'hC;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if (rdata1 !== ((i < 6) ? 4'h3 : 4'hC)) begin
        n_err++; $display("FAIL hold_rdata%0d: got %h want %h", i, rdata1, (i < 6) ? 4'h3 : 4'hC);
      end
      if (ack1) we1 = 1'b0;
    end
    req1 = 1'b0;
    n_checks++;
    if (obs !== exp_v) begin n_err++; $display("FAIL hold_final: got %h want %h", obs, exp_v); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int a = 0; a < 256; a++) poke(8'(a), 4'($urandom_range(15)));
    for (int i = 0; i < 400; i++) begin
      if (ack0 ? ($urandom_range(1) == 1) : (!req0 && $urandom_range(2) == 0)) begin
        req0 = 1'b1; we0 = 1'($urandom_range(1));
        addr0 = 8'($urandom_range(15)); wdata0 = 4'($urandom_range(15));
      end else if (ack0) req0 = 1'b0;
      if (ack1 ? ($urandom_range(1) == 1) : (!req1 && $urandom_range(2) == 0)) begin
        req1 = 1'b1; we1 = 1'($urandom_range(1));
        addr1 = 8'($urandom_range(15)); wdata1 = 4'($urandom_range(15));
      end else if (ack1) req1 = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_v) begin n_err++; $display("FAIL rand_cycle%0d: got %h want %h", i, obs, exp_v); end
      n_checks++;
      if ((gnt0 && gnt1) || (ack0 && ack1)) begin
        n_err++; $display("FAIL rand_exclusive: got gnt %b%b ack %b%b want one-hot", gnt0, gnt1, ack0, ack1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_sole();
    test_reset_mid();
    test_rdata_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester round-robin arbiter and access sequencer for the 8-bit-address scratch memory. It serialises read and write transactions from requester 0 (fetch side) and requester 1 (data side) onto the single memory port. Each requester uses a req/ack handshake. The arbiter drives the memory's read/write address, data and write-enable from registered values, so the memory sees stable inputs for a full cycle.

Parameters:
ADDR_WIDTH, 8, memory address width
DATA_WIDTH, 4, memory line width (matches memory LINE_WIDTH)
CELL_COUNT, 256, number of memory cells; used by the clear sweep

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
req0  input  1  requester 0 transaction request, level
we0  input  1  requester 0: 1 = write, 0 = read; held stable while req0=1
addr0  input  ADDR_WIDTH  requester 0 address; held stable while req0=1
wdata0  input  DATA_WIDTH  requester 0 write data; held stable while req0=1
gnt0  output  1  requester 0 owns memory this cycle (ACCESS)
ack0  output  1  one-cycle completion pulse for requester 0
rdata0  output  DATA_WIDTH  requester 0 read result, registered
req1, we1, addr1, wdata1, gnt1, ack1, rdata1  same as above, for requester 1
mem_read_address  output  ADDR_WIDTH  to memory read_address
mem_write_address  output  ADDR_WIDTH  to memory write_address
mem_write_data  output  DATA_WIDTH  to memory write_data
mem_write_enable  output  1  to memory write_enable
mem_read_data  input  DATA_WIDTH  from memory read_data
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, last_grant=1 (requester 0 wins the first tie). gnt*/ack*/mem_write_enable/busy=0. rdata*=0. mem addresses and data=0. Any in-flight transaction is dropped with no ack.
- FSM: IDLE -> ACCESS -> DONE -> IDLE. Full transaction is 3 cycles; throughput is one transaction per 3 cycles.
- IDLE, at the rising edge:
  - Sample req0/req1.
  - Only one request: select it.
  - Both requests: select the requester != last_grant.
  - Latch the selected we/addr/wdata into internal registers, set last_grant=selected, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS, one cycle:
  - gnt<sel>=1.
  - mem_read_address and mem_write_address = latched addr.
  - mem_write_data = latched wdata.
  - mem_write_enable = latched we.
  - At the end of the cycle, for a read, capture mem_read_data into rdata<sel>. Go to DONE.
- DONE, one cycle:
  - ack<sel>=1; rdata<sel> is valid.
  - mem_write_enable=0; addresses and data hold their values.
  - req inputs are ignored. Go to IDLE.
- Requester protocol: hold req and its operands stable until the ack cycle. Deassert at the edge ending the ack cycle. A req still high in IDLE is a new transaction.
- rdata<i> holds its value until the next read completes for that requester. Writes never change rdata.
- Outside ACCESS, mem_write_enable=0.
- gnt0 and gnt1 are never high together. ack0 and ack1 are never high together.
- A req that drops before being sampled in IDLE is never served.
- A requester that is sole requester repeatedly is served every 3 cycles. Round-robin applies only on ties.

Optional Feature:
MEM_ARB_CLEAR_EN
- Defined:
  - On reset_n release, enter state CLEAR. An address counter sweeps 0..CELL_COUNT-1, one cell per cycle, with mem_write_address=counter, mem_write_data=0 and mem_write_enable=1.
  - busy=1 throughout; no grants are issued. Requests stay pending and are sampled in IDLE.
  - After writing cell CELL_COUNT-1 (CELL_COUNT cycles), go to IDLE. Reset during CLEAR restarts the sweep at 0.
- Undefined: no CLEAR state; reset goes directly to IDLE, and memory contents are owned by the memory's own reset.

Test Plan:
- Write then read: req0 we0=1 addr0=0x10 wdata0=0xA, then req0 we0=0 addr0=0x10 -> mem_write_enable high exactly one cycle, with gnt0; ack0 2 cycles after sample; rdata0=0xA on the read ack.
- Tie round-robin: req0 and req1 held high continuously with reads from 0x01/0x02 -> grants ordered 0,1,0,1; acks every 3 cycles; never both gnt.
- Sole requester: only req1 held high for 4 transactions -> gnt1 every 3 cycles; gnt0 stays 0; rdata0 unchanged.
- Reset mid-access: assert reset_n=0 during ACCESS of a write to 0x20 -> all outputs 0 immediately, no ack, state IDLE after release.
- Write does not disturb rdata: read 0x05 (value 0x3) by requester 1, then write 0x05=0xC by requester 1 -> rdata1 stays 0x3 until next read returns 0xC.
- With MEM_ARB_CLEAR_EN: preload memory, release reset with req0 read of 0xFF pending -> busy=1 for 256 cycles, zero-writes to 0x00..0xFF, then grant; rdata0=0.
